// File: rtl/accum_pkg.sv
// Shared types and default sizing for the accumulator scheduler.
package accum_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int LEN_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DONE
  } acc_state_e;

endpackage

// File: rtl/accum_rr_arb.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module accum_rr_arb
  import accum_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         win,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [IDX_W-1:0] j;
      j = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any && req[j]) begin
        any     = 1'b1;
        win_idx = j;
        win[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Round-robin scheduler sharing one accumulator among NUM_REQ requesters;
// each grant clears the sum, takes exactly len beats, then returns a tagged total.
module accum_sched
  import accum_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   len,
  output logic [NUM_REQ-1:0]         grant,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  input  logic [NUM_REQ-1:0]         data_valid,
  output logic [NUM_REQ-1:0]         data_ready,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(NUM_REQ)-1:0] result_id,
  output logic                       result_ovf,
  output logic                       result_valid,
  input  logic                       result_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);

  acc_state_e         state, state_d;
  logic [IDX_W-1:0]   owner, rr_ptr, win_idx;
  logic [NUM_REQ-1:0] owner_oh, win_oh;
  logic               any;
  logic [LEN_W-1:0]   len_q, cnt;
  logic [WIDTH-1:0]   sum, beat_data;
  logic               ovf, beat, last_beat;
  logic [WIDTH:0]     add_res;

  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  accum_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  assign beat_data = data[int'(owner)*WIDTH +: WIDTH];
  assign beat      = (state == ACCUM) && data_valid[owner];
  assign last_beat = beat && ((cnt + 1'b1) == len_q);
  assign add_res   = add_carry(sum, beat_data);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (any) state_d = CLEAR;
      CLEAR:   state_d = (len_q == '0) ? DONE : ACCUM;
      ACCUM:   if (last_beat) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // owner and len are captured only in IDLE, so later req/len changes cannot disturb a burst
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      owner_oh <= '0;
      len_q    <= '0;
      cnt      <= '0;
      sum      <= '0;
      ovf      <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (any) begin
            owner    <= win_idx;
            owner_oh <= win_oh;
            len_q    <= len[int'(win_idx)*LEN_W +: LEN_W];
          end
        end
        CLEAR: begin
          sum <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
        ACCUM: begin
          if (beat) begin
            sum <= add_res[WIDTH-1:0];
            cnt <= cnt + 1'b1;
            ovf <= ovf | add_res[WIDTH];
          end
        end
        DONE: begin
          if (result_ready)
            rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // outputs decode registered state only
  assign grant        = (state != IDLE)  ? owner_oh : '0;
  assign data_ready   = (state == ACCUM) ? owner_oh : '0;
  assign result       = sum;
  assign result_id    = owner;
  assign result_ovf   = ovf;
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_accum_sched.sv
// Randomized scoreboard bench for accum_sched: a queue-based reference model predicts
// the round-robin winner and each burst's total; a negedge monitor checks every result.
module tb_accum_sched;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int LW = 8;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*LW-1:0]   len;
  logic [N-1:0]      grant;
  logic [N*W-1:0]    data;
  logic [N-1:0]      data_valid;
  logic [N-1:0]      data_ready;
  logic [W-1:0]      result;
  logic [IW-1:0]     result_id;
  logic              result_ovf;
  logic              result_valid;
  logic              result_ready;

  always #5 clk = ~clk;

  accum_sched #(.WIDTH(W), .NUM_REQ(N), .LEN_W(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .len          (len),
    .grant        (grant),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .result       (result),
    .result_id    (result_id),
    .result_ovf   (result_ovf),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       ovf;
    int         len;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] lane_q[N][$];
  int           burst_q[N][$];
  int           total = 0;
  int           bad = 0;
  int           model_ptr = 0;
  int           vld_pct = 100;
  int           rdy_pct = 100;
  bit           hold_rdy_low = 1'b0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] take = '0;

  task automatic check(input bit ok, input string name, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (burst_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (burst_q[i].size() != 0);
      len[i*LW +: LW] = req[i] ? LW'(burst_q[i][0]) : LW'($urandom);
      if (lane_q[i].size() != 0) begin
        data_valid[i]  = ($urandom_range(0, 99) < vld_pct);
        data[i*W +: W] = lane_q[i][0];
      end else begin
        data_valid[i]  = ($urandom_range(0, 99) < 30);
        data[i*W +: W] = $urandom;
      end
    end
    result_ready = !hold_rdy_low && ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic add_beat(input int lane, input logic [W-1:0] v);
    lane_q[lane].push_back(v);
  endtask

  task automatic add_burst(input int lane, input int n);
    burst_q[lane].push_back(n);
    drive();
  endtask

  // Model: winner is the first pending requester at/after the pointer; total is the plain sum.
  task automatic on_grant();
    int     w = -1;
    int     n;
    longint s = 0;
    for (int k = 0; k < N; k++) begin
      int j = (model_ptr + k) % N;
      if (w < 0 && burst_q[j].size() != 0) w = j;
    end
    check(w >= 0 && grant == (N'(1) << w), "grant",
          $sformatf("grant=%b required one-hot of requester %0d", grant, w));
    if (w < 0) return;
    n = burst_q[w].pop_front();
    for (int k = 0; k < n; k++) s += longint'(lane_q[w][k]);
    exp_q.push_back('{id: w, sum: s[W-1:0], ovf: (s >= 64'h1_0000_0000), len: n});
    model_ptr = (w + 1) % N;
  endtask

  task automatic cycle();
    @(negedge clk);
    take = data_valid & data_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (take[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
    if (reset && grant != '0 && prev_grant == '0) on_grant();
    prev_grant = grant;
    drive();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((pending() || exp_q.size() != 0 || grant != '0) && n < budget) begin
      cycle();
      n++;
    end
    check(n < budget, name, $sformatf("still busy after %0d cycles, required idle", n));
  endtask

  // Monitor
  int           cyc = 0;
  int           rem = 0;
  int           last_hs = 0;
  logic [N-1:0] pg_m = '0;
  logic         prv_rv = 1'b0;
  logic         held = 1'b0;
  logic [W-1:0] h_res;
  logic [IW-1:0] h_id;
  logic         h_ovf;
  logic [N-1:0] h_g;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        exp_q.delete();
        rem  = 0;
        held = 1'b0;
      end else begin
        if (grant != '0 && pg_m == '0) rem = (exp_q.size() != 0) ? exp_q[0].len : 0;
        if (data_ready != '0)
          check((data_ready & ~grant) == '0 && $onehot(data_ready) && rem > 0, "ready",
                $sformatf("data_ready=%b grant=%b beats_left=%0d, required owner-only with beats left",
                          data_ready, grant, rem));
        if ((data_valid & data_ready) != '0) begin
          rem--;
          last_hs = cyc;
        end
        if (result_valid && !prv_rv && exp_q.size() != 0 && exp_q[0].len > 0)
          check(cyc == last_hs + 1, "latency",
                $sformatf("result_valid at cycle %0d, required %0d", cyc, last_hs + 1));
        if (held)
          check(result_valid && result == h_res && result_id == h_id && result_ovf == h_ovf && grant == h_g,
                "hold", $sformatf("valid=%b res=%h id=%0d ovf=%b grant=%b, required 1 %h %0d %b %b",
                                  result_valid, result, result_id, result_ovf, grant, h_res, h_id, h_ovf, h_g));
        held = 1'b0;
        if (result_valid) begin
          if (result_ready) begin
            check(exp_q.size() != 0, "result_expected",
                  $sformatf("result id=%0d sum=%h with nothing expected", result_id, result));
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check(result == e.sum && int'(result_id) == e.id && result_ovf == e.ovf &&
                    grant == (N'(1) << e.id), "result",
                    $sformatf("id=%0d sum=%h ovf=%b grant=%b, required id=%0d sum=%h ovf=%b",
                              result_id, result, result_ovf, grant, e.id, e.sum, e.ovf));
            end
          end else begin
            held  = 1'b1;
            h_res = result;
            h_id  = result_id;
            h_ovf = result_ovf;
            h_g   = grant;
          end
        end
      end
      pg_m   = grant;
      prv_rv = result_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    drive();
    repeat (3) cycle();
    check(grant == '0 && data_ready == '0 && result == '0 && result_id == '0 && !result_ovf && !result_valid,
          "reset_state", $sformatf("grant=%b rdy=%b res=%h id=%0d ovf=%b vld=%b, required all zero",
                                   grant, data_ready, result, result_id, result_ovf, result_valid));
    reset = 1'b1;
    cycle();

    // contiguous burst on requester 0
    for (int k = 1; k <= 4; k++) add_beat(0, W'(k));
    add_burst(0, 4);
    wait_idle(50, "t1_done");

    // gapped burst on requester 1 while other lanes toggle valid
    vld_pct = 35;
    for (int k = 1; k <= 4; k++) add_beat(1, W'(k));
    add_burst(1, 4);
    wait_idle(200, "t2_done");
    vld_pct = 100;

    // all requesters with len=1, requester 0 twice
    for (int i = 0; i < N; i++) add_beat(i, W'(i + 1));
    add_beat(0, W'(1));
    for (int i = 0; i < N; i++) add_burst(i, 1);
    add_burst(0, 1);
    wait_idle(100, "t3_done");

    // zero-length burst
    add_burst(3, 0);
    wait_idle(20, "t4_done");

    // wrap-around
    add_beat(2, 32'hFFFF_FFFF);
    add_beat(2, 32'h0000_0002);
    add_burst(2, 2);
    wait_idle(30, "t5_done");

    // random traffic with stalls and backpressure
    vld_pct = 70;
    rdy_pct = 60;
    for (int b = 0; b < 40; b++) begin
      int lane = $urandom_range(0, N - 1);
      int bl   = $urandom_range(0, 6);
      for (int k = 0; k < bl; k++)
        add_beat(lane, ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | W'($urandom_range(0, 15))) : W'($urandom));
      add_burst(lane, bl);
    end
    wait_idle(3000, "rand_done");
    vld_pct = 100;
    rdy_pct = 100;

    // held result under backpressure
    hold_rdy_low = 1'b1;
    for (int k = 0; k < 3; k++) add_beat(1, W'($urandom));
    add_burst(1, 3);
    n = 0;
    while (!result_valid && n < 30) begin
      cycle();
      n++;
    end
    check(result_valid, "bp_reach_done", $sformatf("result_valid=%b after %0d cycles, required 1", result_valid, n));
    repeat (5) cycle();
    hold_rdy_low = 1'b0;
    drive();
    wait_idle(20, "bp_done");

    // reset in the middle of a burst
    add_beat(1, W'(5));
    add_burst(1, 1);
    wait_idle(20, "pre_reset_done");
    for (int k = 0; k < 10; k++) add_beat(2, W'(k + 7));
    add_burst(2, 10);
    n = 0;
    while (!data_ready[2] && n < 20) begin
      cycle();
      n++;
    end
    check(data_ready[2], "reach_accum", $sformatf("data_ready=%b after %0d cycles, required lane 2 ready", data_ready, n));
    repeat (2) cycle();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check(grant == '0 && data_ready == '0 && result == '0 && result_id == '0 && !result_ovf && !result_valid,
          "reset_async", $sformatf("grant=%b rdy=%b res=%h id=%0d ovf=%b vld=%b, required all zero",
                                   grant, data_ready, result, result_id, result_ovf, result_valid));
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete();
      burst_q[i].delete();
    end
    model_ptr = 0;
    drive();
    repeat (3) cycle();
    reset = 1'b1;
    add_beat(0, W'(3));
    add_beat(0, W'(4));
    add_beat(3, W'(9));
    add_beat(3, W'(1));
    add_burst(0, 2);
    add_burst(3, 2);
    wait_idle(50, "post_reset_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
